// File: rtl/clock_div_pkg.sv
// Shared defaults and channel-state layout for the programmable clock divider bank.
package clock_div_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_DIV   = 16384;

  // Channel state at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] div;
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_CNT_W-1:0] pend_div;
    logic                 pend;
  } ch_state_t;

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: wrap counter, pending-divisor register, registered tick and clk_out.
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic             pend;
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t st, st_n;
  logic   tick_n, clk_out_n;
  logic   wrap;

  assign wrap = (st.cnt == st.div - ONE);
  assign pend = st.pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= '{div: CNT_W'(RST_DIV), cnt: '0, pend_div: '0, pend: 1'b0};
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      st      <= st_n;
      tick    <= tick_n;
      clk_out <= clk_out_n;
    end
  end

  always_comb begin
    st_n      = st;
    tick_n    = 1'b0;
    clk_out_n = clk_out;
    if (sync_clear) begin
      st_n.cnt  = '0;
      st_n.pend = 1'b0;
      clk_out_n = 1'b0;
      if (load)         st_n.div = load_div;
      else if (st.pend) st_n.div = st.pend_div;
    end else if (st.div == '0) begin
      // Disabled: a load takes effect at once, nothing is left pending.
      st_n.cnt  = '0;
      clk_out_n = 1'b0;
      if (load) st_n.div = load_div;
    end else if (!en) begin
      if (load) begin
        st_n.pend_div = load_div;
        st_n.pend     = 1'b1;
      end
    end else begin
      if (wrap) begin
        st_n.cnt  = '0;
        st_n.pend = 1'b0;
        tick_n    = 1'b1;
        if (load)         st_n.div = load_div;
        else if (st.pend) st_n.div = st.pend_div;
      end else begin
        st_n.cnt = st.cnt + ONE;
        if (load) begin
          st_n.pend_div = load_div;
          st_n.pend     = 1'b1;
        end
      end
      clk_out_n = (st.div >= TWO) && (st_n.cnt >= (st.div >> 1));
    end
  end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers with a shared valid/ready divisor-load port.
module clock_div_bank
  import clock_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clear,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic [NUM_CH-1:0] pend;
  logic              ch_valid;
  logic              accept;

  // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
  if ((2 ** CH_W) > NUM_CH) begin : g_range
    assign ch_valid = (32'(cfg_ch) < NUM_CH);
  end else begin : g_full
    assign ch_valid = 1'b1;
  end

  assign cfg_ready = ch_valid ? !pend[cfg_ch] : 1'b1;
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_div_ch #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sync_clear (sync_clear),
      .load       (accept && (32'(cfg_ch) == 32'(i))),
      .load_div   (cfg_div),
      .tick       (tick[i]),
      .clk_out    (clk_out[i]),
      .pend       (pend[i])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank: directed tables, hand sequences and a randomized phase against a period model.
module tb_clock_div_bank;

  logic        clk = 1'b0;
  logic        rst, en, sync_clear, cfg_valid, cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  tick, clk_out;

  logic        s_rst, s_en, s_sync, s_cfg_valid, s_ready;
  logic [1:0]  s_cfg_ch;
  logic [7:0]  s_cfg_div;
  logic [2:0]  s_tick, s_clk_out;

  always #5 clk = ~clk;

  clock_div_bank #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(16384)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sync_clear(sync_clear),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .clk_out(clk_out)
  );

  clock_div_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .sync_clear(s_sync),
    .cfg_valid(s_cfg_valid), .cfg_ready(s_ready), .cfg_ch(s_cfg_ch), .cfg_div(s_cfg_div),
    .tick(s_tick), .clk_out(s_clk_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: each channel tracks cycles elapsed in its current period.
  int unsigned m_div[4], m_pos[4], m_pdiv[4];
  bit          m_pend[4], m_tick[4], m_clk[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 16384; m_pos[i] = 0; m_pdiv[i] = 0;
      m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      bit acc;
      int unsigned od;
      acc = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
      od  = m_div[i];
      m_tick[i] = 0;
      if (sync_clear) begin
        m_pos[i] = 0; m_clk[i] = 0;
        if (acc) m_div[i] = cfg_div;
        else if (m_pend[i]) m_div[i] = m_pdiv[i];
        m_pend[i] = 0;
      end else if (od == 0) begin
        m_pos[i] = 0; m_clk[i] = 0;
        if (acc) m_div[i] = cfg_div;
      end else if (!en) begin
        if (acc) begin m_pdiv[i] = cfg_div; m_pend[i] = 1; end
      end else begin
        if (m_pos[i] + 1 == od) begin
          m_pos[i] = 0; m_tick[i] = 1;
          if (acc) m_div[i] = cfg_div;
          else if (m_pend[i]) m_div[i] = m_pdiv[i];
          m_pend[i] = 0;
        end else begin
          m_pos[i]++;
          if (acc) begin m_pdiv[i] = cfg_div; m_pend[i] = 1; end
        end
        m_clk[i] = (od >= 2) && (m_pos[i] >= od / 2);
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4 + i] = m_tick[i];
      v[i]     = m_clk[i];
    end
    return v;
  endfunction

  // One clock: check cfg_ready before the edge, advance model, check outputs 1 after.
  task automatic step();
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend[cfg_ch]});
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("outputs", {24'd0, tick, clk_out}, {24'd0, model_out()});
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < budget);
  endtask

  typedef struct {
    int   cyc;
    logic t0;
    logic c0;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   exp_c1[10];
    int   exp_t1[10];
    int   exp_t2[6];
    int   n;
    logic saved;

    vecs[0] = '{8191,  1'b0, 1'b0};
    vecs[1] = '{8192,  1'b0, 1'b1};
    vecs[2] = '{16383, 1'b0, 1'b1};
    vecs[3] = '{16384, 1'b1, 1'b0};
    vecs[4] = '{24575, 1'b0, 1'b0};
    vecs[5] = '{24576, 1'b0, 1'b1};
    vecs[6] = '{32768, 1'b1, 1'b0};
    exp_c1 = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    exp_t1 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_t2 = '{0, 0, 1, 0, 0, 1};

    rst = 1; en = 0; sync_clear = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
    s_rst = 1; s_en = 1; s_sync = 0; s_cfg_valid = 0; s_cfg_ch = 0; s_cfg_div = 0;
    model_reset();
    #3;
    chk("reset_tick", {28'd0, tick}, 32'd0);
    chk("reset_clk_out", {28'd0, clk_out}, 32'd0);
    chk("reset_ready", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 0; en = 1; cyc = 0;

    // Default divisor: first tick on cycle 16384, clk_out half-period phases.
    foreach (vecs[k]) begin
      while (cyc < vecs[k].cyc) step();
      chk("default_tick0", {31'd0, tick[0]}, {31'd0, vecs[k].t0});
      chk("default_clk0", {31'd0, clk_out[0]}, {31'd0, vecs[k].c0});
    end

    // Mid-period loads: ch1=5, ch2=0, ch0=4, all pending until the shared wrap.
    repeat (100) step();
    cfg_valid = 1; cfg_ch = 1; cfg_div = 5; step();
    cfg_ch = 2; cfg_div = 0; step();
    cfg_ch = 0; cfg_div = 4; step();
    cfg_valid = 0; cfg_ch = 1; #1;
    chk("ready_low_pending", {31'd0, cfg_ready}, 32'd0);
    wait_tick(1, 20000, n);
    chk("ch1_old_period_done", cyc, 49152);
    #1;
    chk("ready_after_wrap", {31'd0, cfg_ready}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("ch1_clk_out", {31'd0, clk_out[1]}, exp_c1[k]);
      chk("ch1_tick", {31'd0, tick[1]}, exp_t1[k]);
      chk("ch2_disabled", {30'd0, tick[2], clk_out[2]}, 32'd0);
    end

    // Load into disabled ch2 applies immediately.
    cfg_valid = 1; cfg_ch = 2; cfg_div = 3; step();
    cfg_valid = 0; #1;
    chk("ch2_no_pending", {31'd0, cfg_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ch2_tick", {31'd0, tick[2]}, exp_t2[k]);
    end

    // Accept on ch0's wrap edge: 4 -> 7 with nothing left pending.
    for (int k = 0; k < 8 && m_pos[0] != 3; k++) step();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 7; step();
    chk("wrap_accept_tick", {31'd0, tick[0]}, 32'd1);
    cfg_valid = 0; #1;
    chk("wrap_accept_ready", {31'd0, cfg_ready}, 32'd1);
    wait_tick(0, 20, n);
    chk("ch0_new_period", n, 7);

    // en low for 10 cycles mid-period.
    repeat (3) step();
    chk("ch0_clk_mid", {31'd0, clk_out[0]}, 32'd1);
    saved = clk_out[0];
    en = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("frozen_tick", {28'd0, tick}, 32'd0);
      chk("frozen_clk0", {31'd0, clk_out[0]}, {31'd0, saved});
    end
    en = 1;
    wait_tick(0, 20, n);
    chk("resume_remaining", n, 4);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cfg_valid  = ($urandom % 3) == 0;
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_div    = 16'($urandom_range(0, 9));
      en         = ($urandom % 8) != 0;
      sync_clear = ($urandom % 40) == 0;
      step();
    end

    // sync_clear aligns all channels at div=6.
    cfg_valid = 0; en = 1; sync_clear = 1; step();
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1; cfg_ch = 2'(i); cfg_div = 6; step();
    end
    cfg_valid = 0; sync_clear = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("aligned_ticks", {28'd0, tick}, (k % 6 == 0) ? 32'hF : 32'h0);
    end
    repeat (4) step();
    chk("aligned_clk_high", {28'd0, clk_out}, 32'hF);

    // Asynchronous reset mid-cycle clears outputs at once.
    #2; rst = 1; #1;
    chk("async_rst_tick", {28'd0, tick}, 32'd0);
    chk("async_rst_clk", {28'd0, clk_out}, 32'd0);
    model_reset();

    // Out-of-range channel on a 3-channel bank: accepted and dropped.
    @(posedge clk); #1;
    s_rst = 0; s_cfg_valid = 1; s_cfg_ch = 3; s_cfg_div = 2; #1;
    chk("oob_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_cfg_valid = 0;
    chk("oob_tick_1", {29'd0, s_tick}, 32'd0);
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("oob_no_effect", {29'd0, s_tick}, (k % 4 == 0) ? 32'h7 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
